// File: rtl/spi_master_ctrl.sv
// SPI mode-0 initiator: one transaction is an 8-bit command byte followed by
// DATA_BITS of payload, MSB first. The miso stream is captured into rx_status
// (command phase) and rx_data (payload phase). Chip select is framed by setup,
// hold and gap intervals. All outputs are registered.
module spi_master_ctrl #(
    parameter int CLK_DIV   = 4,
    parameter int DATA_BITS = 32,
    parameter int CS_SETUP  = 4,
    parameter int CS_HOLD   = 4,
    parameter int CS_GAP    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [7:0]           cmd,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           rx_status,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 sck,
    output logic                 ncs,
    output logic                 mosi,
    input  logic                 miso
);

    localparam int TOTAL   = 8 + DATA_BITS;
    localparam int BIT_W   = $clog2(TOTAL + 1);
    localparam int MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_B   = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(TOTAL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [BIT_W-1:0]       r_bit;
    logic [TOTAL-1:0]       r_tx;
    logic [TOTAL-1:0]       r_rx;
    logic                   r_sck;
    logic                   r_ncs;
    logic                   r_busy;
    logic                   r_done;
    logic [7:0]             r_rx_status;
    logic [DATA_BITS-1:0]   r_rx_data;

    // mosi is the MSB of the tx shift register, so it stays put between falls
    // and naturally holds the last bit once shifting stops.
    assign mosi      = r_tx[TOTAL-1];
    assign sck       = r_sck;
    assign ncs       = r_ncs;
    assign busy      = r_busy;
    assign done      = r_done;
    assign rx_status = r_rx_status;
    assign rx_data   = r_rx_data;

    // Transaction sequencer: frames ncs, generates sck and shifts both data directions.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // sees the pre-edge values of the others, independent of statement order.
        if (!rst_n) begin
            // NOTE: reset returns every register, including the rx outputs, to a
            // known value; a mid-transfer reset therefore also drops ncs and sck at once.
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_sck       <= 1'b0;
            r_ncs       <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rx_status <= '0;
            r_rx_data   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_tx    <= {cmd, wr_data};
                        r_ncs   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != DIV_LAST) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_cnt <= '0;
                        if (!r_sck) begin
                            // Rising edge: capture the slave's bit.
                            r_sck <= 1'b1;
                            r_rx  <= {r_rx[TOTAL-2:0], miso};
                        end else begin
                            // Falling edge: advance mosi unless this was the last bit.
                            r_sck <= 1'b0;
                            r_bit <= r_bit + BIT_W'(1);
                            if (r_bit == BIT_LAST) begin
                                r_state <= S_HOLD;
                            end else begin
                                r_tx <= {r_tx[TOTAL-2:0], 1'b0};
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_cnt       <= '0;
                        r_ncs       <= 1'b1;
                        r_done      <= 1'b1;
                        r_rx_status <= r_rx[TOTAL-1:DATA_BITS];
                        r_rx_data   <= r_rx[DATA_BITS-1:0];
                        r_state     <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl. Three instances: defaults with a
// (optionally inverting) loopback, CLK_DIV=2 against a small register-slave
// model, and DATA_BITS=16 with start held high for back-to-back transfers.
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- instance A: defaults, loopback ----------------
    logic        a_rst_n = 1'b0, a_start = 1'b0, a_inv = 1'b0;
    logic [7:0]  a_cmd = '0;
    logic [31:0] a_wr = '0;
    logic        a_busy, a_done, a_sck, a_ncs, a_mosi, a_miso;
    logic [7:0]  a_rx_status;
    logic [31:0] a_rx_data;
    assign a_miso = a_inv ? ~a_mosi : a_mosi;

    spi_master_ctrl u_a (
        .clk(clk), .rst_n(a_rst_n), .start(a_start), .cmd(a_cmd), .wr_data(a_wr),
        .busy(a_busy), .done(a_done), .rx_status(a_rx_status), .rx_data(a_rx_data),
        .sck(a_sck), .ncs(a_ncs), .mosi(a_mosi), .miso(a_miso)
    );

    // Protocol monitor: sck must not toggle while ncs is high, ncs must not move while sck is high.
    logic a_mon_en = 1'b0;
    logic m_prev_sck = 1'b0, m_prev_ncs = 1'b1;
    int   a_viol = 0;
    always @(negedge clk) begin
        m_prev_sck <= a_sck;
        m_prev_ncs <= a_ncs;
        if (a_mon_en && a_rst_n) begin
            if (a_ncs && m_prev_ncs && (a_sck !== m_prev_sck))
                a_viol <= a_viol + 1;
            else if ((a_ncs !== m_prev_ncs) && (a_sck || m_prev_sck))
                a_viol <= a_viol + 1;
        end
    end

    // ---------------- instance B: CLK_DIV=2, register slave ----------------
    logic        b_rst_n = 1'b0, b_start = 1'b0;
    logic [7:0]  b_cmd = '0;
    logic [31:0] b_wr = '0;
    logic        b_busy, b_done, b_sck, b_ncs, b_mosi, b_miso;
    logic [7:0]  b_rx_status;
    logic [31:0] b_rx_data;

    spi_master_ctrl #(.CLK_DIV(2)) u_b (
        .clk(clk), .rst_n(b_rst_n), .start(b_start), .cmd(b_cmd), .wr_data(b_wr),
        .busy(b_busy), .done(b_done), .rx_status(b_rx_status), .rx_data(b_rx_data),
        .sck(b_sck), .ncs(b_ncs), .mosi(b_mosi), .miso(b_miso)
    );

    // Slave: status 8'h0A during command; write stores payload, read returns register.
    logic        s_prev_sck = 1'b0;
    logic [39:0] s_tx = '0;
    logic [38:0] s_in = '0;
    int          s_cnt = 0;
    logic [31:0] s_reg [4] = '{default: 32'h0};
    assign b_miso = s_tx[39];
    always @(negedge clk) begin
        s_prev_sck <= b_sck;
        if (b_ncs === 1'b1) begin
            s_tx  <= {8'h0A, 32'h0};
            s_in  <= '0;
            s_cnt <= 0;
        end else if (b_sck && !s_prev_sck) begin
            s_in  <= {s_in[37:0], b_mosi};
            s_cnt <= s_cnt + 1;
            if (s_cnt == 39 && s_in[33])
                s_reg[s_in[32:31]] <= {s_in[30:0], b_mosi};
        end else if (!b_sck && s_prev_sck) begin
            if (s_cnt == 8 && !s_in[2])
                s_tx <= {s_reg[s_in[1:0]], 8'h00};
            else
                s_tx <= {s_tx[38:0], 1'b0};
        end
    end

    // ---------------- instance C: DATA_BITS=16, back-to-back ----------------
    logic        c_rst_n = 1'b0, c_start = 1'b0;
    logic [7:0]  c_cmd = '0;
    logic [15:0] c_wr = '0;
    logic        c_busy, c_done, c_sck, c_ncs, c_mosi, c_miso;
    logic [7:0]  c_rx_status;
    logic [15:0] c_rx_data;
    assign c_miso = c_mosi;

    spi_master_ctrl #(.DATA_BITS(16)) u_c (
        .clk(clk), .rst_n(c_rst_n), .start(c_start), .cmd(c_cmd), .wr_data(c_wr),
        .busy(c_busy), .done(c_done), .rx_status(c_rx_status), .rx_data(c_rx_data),
        .sck(c_sck), .ncs(c_ncs), .mosi(c_mosi), .miso(c_miso)
    );

    // ---------------- vector table for instance A ----------------
    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] data;
        logic        inv;
        logic [7:0]  exp_status;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vecs [5];

    // One default-parameter transaction; cycle k = k-th clock after start is sampled.
    task automatic run_a(input logic [7:0] cmd, input logic [31:0] data, input logic inv,
                         input int inject, input logic [7:0] exp_st,
                         input logic [31:0] exp_dt, input string tag);
        int   rises, first_rise, ncs_fall, dones, done_at;
        logic prev_sck, prev_ncs, busy_332, busy_333;
        rises = 0; first_rise = -1; ncs_fall = -1; dones = 0; done_at = -1;
        busy_332 = 1'b0; busy_333 = 1'b1;
        @(negedge clk);
        a_cmd = cmd; a_wr = data; a_inv = inv; a_start = 1'b1;
        prev_sck = a_sck; prev_ncs = a_ncs;
        for (int k = 1; k <= 345; k++) begin
            @(negedge clk);
            if (k == 1) a_start = 1'b0;
            if (k == inject) begin
                a_start = 1'b1; a_cmd = 8'h01; a_wr = 32'h0;
            end else if (inject > 0 && k == inject + 1) begin
                a_start = 1'b0;
            end
            if (a_sck && !prev_sck) begin
                rises++;
                if (first_rise < 0) first_rise = k;
            end
            if (!a_ncs && prev_ncs && ncs_fall < 0) ncs_fall = k;
            if (a_done) begin dones++; done_at = k; end
            if (k == 332) busy_332 = a_busy;
            if (k == 333) busy_333 = a_busy;
            prev_sck = a_sck; prev_ncs = a_ncs;
        end
        check({tag, "_done_count"}, 64'(dones), 64'd1);
        check({tag, "_done_cycle"}, 64'(done_at), 64'd329);
        check({tag, "_sck_rises"}, 64'(rises), 64'd40);
        check({tag, "_ncs_fall"}, 64'(ncs_fall), 64'd1);
        check({tag, "_first_rise"}, 64'(first_rise), 64'd9);
        check({tag, "_busy_in_gap"}, 64'(busy_332), 64'd1);
        check({tag, "_busy_after_gap"}, 64'(busy_333), 64'd0);
        check({tag, "_rx_status"}, 64'(a_rx_status), 64'(exp_st));
        check({tag, "_rx_data"}, 64'(a_rx_data), 64'(exp_dt));
    endtask

    // One CLK_DIV=2 transaction against the slave model; waits for idle afterwards.
    task automatic run_b(input logic [7:0] cmd, input logic [31:0] data, input string tag);
        int lat;
        lat = -1;
        @(negedge clk);
        b_cmd = cmd; b_wr = data; b_start = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 1) b_start = 1'b0;
            if (b_done && lat < 0) lat = k;
            if (lat >= 0 && !b_busy) break;
        end
        check({tag, "_latency"}, 64'(lat), 64'd169);
    endtask

    initial begin
        int   dones, rises, gaps, hi;
        int   gap_len [4];
        logic prev_sck, seen_low;

        vecs[0] = '{8'h04, 32'hDEADBEEF, 1'b0, 8'h04, 32'hDEADBEEF};
        vecs[1] = '{8'hA5, 32'h00000001, 1'b1, 8'h5A, 32'hFFFFFFFE};
        vecs[2] = '{8'hFF, 32'hFFFFFFFF, 1'b0, 8'hFF, 32'hFFFFFFFF};
        vecs[3] = '{8'h00, 32'h80000000, 1'b1, 8'hFF, 32'h7FFFFFFF};
        vecs[4] = '{8'h3C, 32'h12345678, 1'b1, 8'hC3, 32'hEDCBA987};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ncs", 64'(a_ncs), 64'd1);
        check("rst_sck", 64'(a_sck), 64'd0);
        check("rst_mosi", 64'(a_mosi), 64'd0);
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_done", 64'(a_done), 64'd0);
        check("rst_rx_status", 64'(a_rx_status), 64'd0);
        check("rst_rx_data", 64'(a_rx_data), 64'd0);
        a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
        a_mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven loopback transfers
        for (int i = 0; i < 5; i++)
            run_a(vecs[i].cmd, vecs[i].data, vecs[i].inv, 0,
                  vecs[i].exp_status, vecs[i].exp_data, $sformatf("vec%0d", i));

        // start with a different cmd/data at cycle 100 of an active transfer is ignored
        run_a(8'h04, 32'hDEADBEEF, 1'b0, 100, 8'h04, 32'hDEADBEEF, "ignored_start");

        // Reset during bit 20 (sck high in cycles 169..172)
        @(negedge clk);
        a_cmd = 8'h55; a_wr = 32'h0F0F0F0F; a_inv = 1'b0; a_start = 1'b1;
        for (int k = 1; k <= 170; k++) begin
            @(negedge clk);
            if (k == 1) a_start = 1'b0;
        end
        check("abort_mid_bit_sck", 64'(a_sck), 64'd1);
        a_mon_en = 1'b0;
        a_rst_n  = 1'b0;
        @(negedge clk);
        check("abort_ncs", 64'(a_ncs), 64'd1);
        check("abort_sck", 64'(a_sck), 64'd0);
        check("abort_busy", 64'(a_busy), 64'd0);
        check("abort_done", 64'(a_done), 64'd0);
        check("abort_rx_status", 64'(a_rx_status), 64'd0);
        check("abort_rx_data", 64'(a_rx_data), 64'd0);
        a_rst_n = 1'b1;
        dones = 0; rises = 0; prev_sck = a_sck;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (a_done) dones++;
            if (a_sck && !prev_sck) rises++;
            prev_sck = a_sck;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        check("abort_no_sck", 64'(rises), 64'd0);
        a_mon_en = 1'b1;
        run_a(8'h04, 32'hDEADBEEF, 1'b0, 0, 8'h04, 32'hDEADBEEF, "post_reset");
        check("protocol_violations", 64'(a_viol), 64'd0);

        // Register slave at CLK_DIV=2
        run_b(8'h04, 32'hDEADBEEF, "b_wr_reg0");
        check("b_wr_reg0_status", 64'(b_rx_status[3:0]), 64'hA);
        run_b(8'h00, 32'h0, "b_rd_reg0");
        check("b_rd_reg0_status", 64'(b_rx_status[3:0]), 64'hA);
        check("b_rd_reg0_data", 64'(b_rx_data), 64'hDEADBEEF);
        run_b(8'h05, 32'h0BADF00D, "b_wr_reg1");
        run_b(8'h01, 32'h0, "b_rd_reg1");
        check("b_rd_reg1_data", 64'(b_rx_data), 64'h0BADF00D);
        run_b(8'h00, 32'h0, "b_rd_reg0_again");
        check("b_rd_reg0_again_data", 64'(b_rx_data), 64'hDEADBEEF);

        // start held high for three back-to-back transfers (DATA_BITS=16)
        @(negedge clk);
        c_cmd = 8'h04; c_wr = 16'hBEEF; c_start = 1'b1;
        dones = 0; gaps = 0; hi = 0; seen_low = 1'b0;
        for (int k = 1; k <= 700; k++) begin
            @(negedge clk);
            if (k == 520) c_start = 1'b0;
            if (c_done) dones++;
            if (c_ncs) begin
                hi++;
            end else begin
                if (seen_low && hi > 0 && gaps < 4) begin
                    gap_len[gaps] = hi;
                    gaps++;
                end
                hi = 0;
                seen_low = 1'b1;
            end
        end
        check("c_done_pulses", 64'(dones), 64'd3);
        check("c_gap_count", 64'(gaps), 64'd2);
        for (int g = 0; g < gaps && g < 4; g++)
            check($sformatf("c_gap%0d_len_in_range(%0d)", g, gap_len[g]),
                  64'(gap_len[g] >= 4 && gap_len[g] <= 5), 64'd1);
        check("c_rx_status", 64'(c_rx_status), 64'h04);
        check("c_rx_data", 64'(c_rx_data), 64'hBEEF);
        check("c_idle_after", 64'(c_busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
